// File: rtl/rv32i_loader_pkg.sv
// Shared definitions for the RV32I program loader: FSM state encoding,
// bytes per instruction word and the width of the image length header.
package rv32i_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_WORD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 32;

endpackage

// File: rtl/rv32i_byte_assembler.sv
// Collects four bytes into one little-endian 32-bit word. The first byte
// lands in bits [7:0]. word_out already includes the byte presented this
// cycle, so it is complete in the cycle word_last is high.
module rv32i_byte_assembler
    import rv32i_loader_pkg::*;
(
    input  logic             clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             byte_in_valid,
    input  logic [7:0]       byte_in,
    output logic [LEN_W-1:0] word_out,
    output logic             word_last
);

    logic [1:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0] shift_q, shift_d;

    // Next byte count and shift contents; clear wins over an incoming byte.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_in_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_in, shift_q[LEN_W-1:8]};
        end
    end

    // Counter and shift register state.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_out  = {byte_in, shift_q[LEN_W-1:8]};
    assign word_last = byte_in_valid && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/rv32i_program_loader.sv
// Boot loader for the single-cycle RV32I core. Receives a 32-bit little-endian
// word count followed by that many instruction words over a byte stream,
// writes them to instruction memory and releases the core reset when done.
// Build option: define RV32I_LOADER_TIMEOUT_EN to add an inter-byte idle
// timeout (TIMEOUT_CYCLES) that drops the loader into the error state.
module rv32i_program_loader
    import rv32i_loader_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int MEM_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-2:0] words_loaded
);

    localparam logic [ADDR_W-2:0] IDX_ONE = {{(ADDR_W-2){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-2:0] word_idx_q, word_idx_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wd_q, imem_wd_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic [LEN_W-1:0]  asm_word;
    logic              asm_last;
    logic [31:0]       idx_next;

    assign rx_ready = !Reset && (state_q == ST_LEN || state_q == ST_WORD);
    assign accept   = rx_valid && rx_ready;
    assign idx_next = 32'(word_idx_q) + 32'd1;

    rv32i_byte_assembler u_asm (
        .clk          (clk),
        .Reset        (Reset),
        .clear        (load_req),
        .byte_in_valid(accept),
        .byte_in      (rx_data),
        .word_out     (asm_word),
        .word_last    (asm_last)
    );

`ifdef RV32I_LOADER_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state logic, write-port staging and registered status decode.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_wd_d   = imem_wd_q;
`ifdef RV32I_LOADER_TIMEOUT_EN
        idle_d      = '0;
`endif
        case (state_q)
            ST_LEN: begin
                if (asm_last) begin
                    len_d = asm_word;
                    if (asm_word == '0)
                        state_d = ST_RUN;
                    else if (asm_word > 32'(MEM_WORDS))
                        state_d = ST_ERR;
                    else
                        state_d = ST_WORD;
                end
            end
            ST_WORD: begin
                if (asm_last) begin
                    state_d     = ST_WRITE;
                    imem_we_d   = 1'b1;
                    imem_addr_d = {word_idx_q[ADDR_W-3:0], 2'b00};
                    imem_wd_d   = asm_word;
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + IDX_ONE;
                state_d    = (idx_next == len_q) ? ST_RUN : ST_WORD;
            end
            default: ;
        endcase
`ifdef RV32I_LOADER_TIMEOUT_EN
        // Idle time counts only while waiting for a byte.
        if ((state_q == ST_LEN || state_q == ST_WORD) && !accept) begin
            idle_d = idle_q + 32'd1;
            if (idle_d == 32'(TIMEOUT_CYCLES - 1))
                state_d = ST_ERR;
        end
        if (state_d != state_q)
            idle_d = '0;
`endif
        // Restart overrides everything; a byte taken this cycle is dropped.
        if (load_req) begin
            state_d     = ST_LEN;
            len_d       = '0;
            word_idx_d  = '0;
            imem_we_d   = 1'b0;
            imem_addr_d = imem_addr_q;
            imem_wd_d   = imem_wd_q;
`ifdef RV32I_LOADER_TIMEOUT_EN
            idle_d      = '0;
`endif
        end
        core_reset_d = (state_d != ST_RUN);
        done_d       = (state_d == ST_RUN);
        err_d        = (state_d == ST_ERR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= ST_LEN;
            len_q        <= '0;
            word_idx_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wd_q    <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef RV32I_LOADER_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wd_q    <= imem_wd_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef RV32I_LOADER_TIMEOUT_EN
            idle_q       <= idle_d;
`endif
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wd      = imem_wd_q;
    assign core_reset   = core_reset_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = word_idx_q;
    assign busy         = (state_q == ST_LEN) || (state_q == ST_WORD) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_rv32i_program_loader.sv
// Self-checking bench for rv32i_program_loader: directed boot scenarios plus
// randomized images with random inter-byte gaps, checked against an
// image-level model (expected write list and final status per image).
module tb_rv32i_program_loader;

    localparam int ADDR_W    = 10;
    localparam int MEM_WORDS = 256;
`ifdef RV32I_LOADER_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1000000;
`endif

    logic              clk;
    logic              Reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              load_req;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-2:0] words_loaded;

    rv32i_program_loader #(
        .ADDR_W        (ADDR_W),
        .MEM_WORDS     (MEM_WORDS),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .load_req    (load_req),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wd     (imem_wd),
        .core_reset  (core_reset),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img [0:MEM_WORDS-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every write pulse must match the next expected (address, data) pair.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                check("wr_addr", 32'(imem_addr), exp_q[0].addr);
                check("wr_data", imem_wd, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    // Present one byte (after an optional random gap) until it is accepted.
    // rx_valid stays high on return; callers drop it when the stream pauses.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        int t;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) begin
                rx_data = 8'($urandom);
                step();
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 64) begin
            step();
            t++;
        end
        if (t >= 64) begin
            check("rx_ready_wait_expired", 32'd0, 32'd1);
        end else begin
            step();
        end
    endtask

    // Send a full image: length header then n words from img[].
    task automatic load_image(input logic [31:0] n, input int gap_max);
        logic [31:0] w;
        if (n <= MEM_WORDS) begin
            for (int i = 0; i < int'(n); i++) exp_q.push_back('{32'(i * 4), img[i]});
        end
        for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], gap_max);
        if (n == 0) begin
            check("len0_done", 32'(done), 32'd1);
            check("len0_core_reset", 32'(core_reset), 32'd0);
            check("len0_err", 32'(err), 32'd0);
            check("len0_words", 32'(words_loaded), 32'd0);
        end else if (n > MEM_WORDS) begin
            check("big_err", 32'(err), 32'd1);
            check("big_core_reset", 32'(core_reset), 32'd1);
            check("big_done", 32'(done), 32'd0);
            check("big_rx_ready", 32'(rx_ready), 32'd0);
            check("big_busy", 32'(busy), 32'd0);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                w = img[i];
                for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap_max);
            end
            // rx_valid is still high here: the held byte must not be taken.
            check("last_write_we", 32'(imem_we), 32'd1);
            check("write_rx_ready", 32'(rx_ready), 32'd0);
            step();
            check("run_done", 32'(done), 32'd1);
            check("run_core_reset", 32'(core_reset), 32'd0);
            check("run_words", 32'(words_loaded), n);
            check("run_rx_ready", 32'(rx_ready), 32'd0);
            check("writes_pending", 32'(exp_q.size()), 32'd0);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        check("lr_core_reset", 32'(core_reset), 32'd1);
        check("lr_done", 32'(done), 32'd0);
        check("lr_err", 32'(err), 32'd0);
        check("lr_words", 32'(words_loaded), 32'd0);
        check("lr_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=still_running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] n;
        int          k;

        Reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        load_req = 1'b0;
        repeat (3) step();
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wd", imem_wd, 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        Reset = 1'b0;
        #1;
        check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

        // Two-instruction program, back-to-back bytes.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        load_image(32'd2, 0);

        // Restart from RUN and reload a single word.
        pulse_load_req();
        img[0] = 32'hDEAD_BEEF;
        load_image(32'd1, 0);

        // Empty image goes straight to RUN.
        pulse_load_req();
        load_image(32'd0, 0);

        // Oversized header (257) lands in ERR; load_req recovers.
        pulse_load_req();
        load_image(32'd257, 0);
        pulse_load_req();

        // Reset in the middle of a word drops the partial word.
        for (int b = 0; b < 4; b++) send_byte(8'(b == 0 ? 1 : 0), 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rx_valid = 1'b0;
        Reset    = 1'b1;
        #1;
        check("midword_rst_rx_ready", 32'(rx_ready), 32'd0);
        step();
        check("midword_rst_words", 32'(words_loaded), 32'd0);
        check("midword_rst_core_reset", 32'(core_reset), 32'd1);
        Reset = 1'b0;
        #1;
        check("midword_post_rx_ready", 32'(rx_ready), 32'd1);
        img[0] = $urandom;
        load_image(32'd1, 1);

        // load_req together with an accepted byte: byte discarded, counters cleared.
        pulse_load_req();
        img[0] = $urandom;
        img[1] = $urandom;
        exp_q.push_back('{32'd0, img[0]});
        n = 32'd2;
        for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], 0);
        for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 0);
        send_byte(img[1][7:0], 0);
        send_byte(img[1][15:8], 0);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        load_req = 1'b1;
        check("discard_rx_ready", 32'(rx_ready), 32'd1);
        step();
        load_req = 1'b0;
        rx_valid = 1'b0;
        check("discard_words", 32'(words_loaded), 32'd0);
        check("discard_core_reset", 32'(core_reset), 32'd1);
        check("discard_pending", 32'(exp_q.size()), 32'd0);
        img[0] = $urandom;
        load_image(32'd1, 0);

        // Stall inside the header.
        pulse_load_req();
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
`ifdef RV32I_LOADER_TIMEOUT_EN
        k = 1;
        while (!err && k < 100) begin
            step();
            k++;
        end
        check("timeout_cycles", 32'(k), 32'd16);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_core_reset", 32'(core_reset), 32'd1);
`else
        k = 0;
        repeat (1000) begin
            step();
            k++;
        end
        check("idle_cycles", 32'(k), 32'd1000);
        check("idle_err", 32'(err), 32'd0);
        check("idle_rx_ready", 32'(rx_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd1);
`endif
        pulse_load_req();

        // Full-capacity image.
        for (int i = 0; i < MEM_WORDS; i++) img[i] = $urandom;
        load_image(32'(MEM_WORDS), 0);

        // Random images with random gaps; last one oversized.
        for (int it = 0; it < 6; it++) begin
            pulse_load_req();
            n = (it == 5) ? 32'($urandom_range(257, 5000)) : 32'($urandom_range(0, 10));
            for (int i = 0; i < MEM_WORDS; i++) img[i] = $urandom;
            load_image(n, 2);
        end

        step();
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
